// File: rtl/stream_demux_pkg.sv
// Shared constants and slot-operation decode for the 1:N stream demultiplexer.
// Optional per-channel pop counters are enabled with STREAM_DEMUX_1_N_COUNT_EN.
package stream_demux_pkg;

  localparam int DEMUX_WIDTH = 4;
  localparam int DEMUX_N     = 4;
  localparam int DEMUX_CNT_W = 8;
  localparam logic [DEMUX_CNT_W-1:0] DEMUX_CNT_MAX = 8'hFF;

  // What a slot does on the coming edge; an accept always wins over a pop
  // because a simultaneous accept+pop simply replaces the word.
  typedef enum logic [1:0] {
    SLOT_HOLD = 2'd0,
    SLOT_LOAD = 2'd1,
    SLOT_POP  = 2'd2
  } slot_op_e;

  function automatic slot_op_e slot_op(input logic load, input logic pop);
    if (load)     return SLOT_LOAD;
    else if (pop) return SLOT_POP;
    else          return SLOT_HOLD;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slot of the demultiplexer: holds a word until
// the consumer takes it. With STREAM_DEMUX_1_N_COUNT_EN it also counts
// completed pops, saturating at DEMUX_CNT_MAX.
module demux_out_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef STREAM_DEMUX_1_N_COUNT_EN
  output logic [DEMUX_CNT_W-1:0] count_o,
`endif
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next slot contents from the load/pop decision.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (slot_op(load_i, pop_i))
      SLOT_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
      SLOT_POP:  valid_d = 1'b0;
      default:   ;
    endcase
  end

  // Slot register; reset empties the slot and clears the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef STREAM_DEMUX_1_N_COUNT_EN
  logic [DEMUX_CNT_W-1:0] count_q, count_d;

  // Saturating pop counter.
  always_comb begin
    count_d = count_q;
    if (pop_i && (count_q != DEMUX_CNT_MAX)) count_d = count_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
`endif

endmodule

// File: rtl/stream_demux_1_n.sv
// 1:N stream demultiplexer: routes each input word to the output slot
// selected by s_sel. A full, stalled slot only blocks words aimed at it.
// Optional per-channel pop counters (m_count) with STREAM_DEMUX_1_N_COUNT_EN.
module stream_demux_1_n
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH = DEMUX_WIDTH,
  parameter  int N     = DEMUX_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  input  logic [SEL_W-1:0]          s_sel,
  output logic [N-1:0]              m_valid,
  input  logic [N-1:0]              m_ready,
`ifdef STREAM_DEMUX_1_N_COUNT_EN
  output logic [N-1:0][DEMUX_CNT_W-1:0] m_count,
`endif
  output logic [N-1:0][WIDTH-1:0]   m_data
);

  logic [N-1:0] load;
  logic [N-1:0] pop;

  // Ready looks only at the addressed slot: free, or being drained this cycle.
  always_comb begin
    s_ready = ~rst & (~m_valid[s_sel] | m_ready[s_sel]);
  end

  // Per-channel accept and pop decode.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      load[i] = s_valid & s_ready & (s_sel == SEL_W'(i));
      pop[i]  = m_valid[i] & m_ready[i];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[g]),
      .pop_i   (pop[g]),
      .data_i  (s_data),
`ifdef STREAM_DEMUX_1_N_COUNT_EN
      .count_o (m_count[g]),
`endif
      .valid_o (m_valid[g]),
      .data_o  (m_data[g])
    );
  end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Self-checking bench for stream_demux_1_n: directed vector table, random
// traffic against a per-channel queue model, and the optional counters.
module tb_stream_demux_1_n;

  localparam int WIDTH = 4;
  localparam int N     = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    s_valid;
  logic                    s_ready;
  logic [WIDTH-1:0]        s_data;
  logic [1:0]              s_sel;
  logic [N-1:0]            m_valid;
  logic [N-1:0]            m_ready;
  logic [N-1:0][WIDTH-1:0] m_data;
`ifdef STREAM_DEMUX_1_N_COUNT_EN
  logic [N-1:0][7:0]       m_count;
`endif

  stream_demux_1_n dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_sel   (s_sel),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef STREAM_DEMUX_1_N_COUNT_EN
    .m_count (m_count),
`endif
    .m_data  (m_data)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic             rst;
    logic             sv;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic [N-1:0]     mr;
    logic             exp_sr;
    logic [N-1:0]     exp_mv;
    logic [15:0]      exp_md;
  } vec_t;

  vec_t vecs[$];

  // Reference model: each channel is a queue of at most one word.
  logic [WIDTH-1:0] chq[N][$];
  logic [WIDTH-1:0] last_d[N];
  logic             exp_sr;
  logic [N-1:0]     exp_mv;
  logic             hold;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sel = '0; m_ready = '0;

    //              rst sv sel data  mr       sr  mv       md
    vecs.push_back('{1, 1, 0, 4'h5, 4'b0000, 0, 4'b0000, 16'h0000});
    vecs.push_back('{1, 1, 0, 4'h5, 4'b0000, 0, 4'b0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 4'h0, 4'b0000, 1, 4'b0000, 16'h0000});
    vecs.push_back('{0, 1, 0, 4'ha, 4'b0000, 1, 4'b0001, 16'h000a});
    vecs.push_back('{0, 1, 1, 4'hb, 4'b0000, 1, 4'b0011, 16'h00ba});
    vecs.push_back('{0, 1, 2, 4'hc, 4'b0000, 1, 4'b0111, 16'h0cba});
    vecs.push_back('{0, 1, 3, 4'hd, 4'b0000, 1, 4'b1111, 16'hdcba});
    vecs.push_back('{0, 1, 2, 4'he, 4'b0000, 0, 4'b1111, 16'hdcba});
    vecs.push_back('{0, 0, 0, 4'h0, 4'b1000, 0, 4'b0111, 16'hdcba});
    vecs.push_back('{0, 1, 3, 4'h7, 4'b0000, 1, 4'b1111, 16'h7cba});
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{0, 1, 2, 4'(k), 4'b0100, 1, 4'b1111, {4'h7, 4'(k), 8'hba}});
    vecs.push_back('{0, 0, 2, 4'h0, 4'b0100, 1, 4'b1011, 16'h78ba});
    vecs.push_back('{1, 1, 0, 4'hf, 4'b0000, 0, 4'b0000, 16'h0000});
    vecs.push_back('{0, 0, 0, 4'h0, 4'b1111, 1, 4'b0000, 16'h0000});
    vecs.push_back('{0, 0, 3, 4'h0, 4'b1111, 1, 4'b0000, 16'h0000});

    foreach (vecs[v]) begin
      rst = vecs[v].rst; s_valid = vecs[v].sv; s_sel = vecs[v].sel;
      s_data = vecs[v].data; m_ready = vecs[v].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_s_ready", v), 32'(s_ready), 32'(vecs[v].exp_sr));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_m_valid", v), 32'(m_valid), 32'(vecs[v].exp_mv));
      chk($sformatf("vec%0d_m_data", v), 32'(m_data), 32'(vecs[v].exp_md));
    end

    // Random traffic; DUT and model are both empty with zero data here.
    for (int i = 0; i < N; i++) last_d[i] = '0;
    hold = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!hold) begin
        s_valid = 1'($urandom_range(0, 1));
        s_sel   = 2'($urandom);
        s_data  = 4'($urandom);
      end
      rst     = ($urandom_range(0, 39) == 0);
      m_ready = 4'($urandom);
      @(negedge clk);
      exp_sr = !rst && ((chq[s_sel].size() == 0) || m_ready[s_sel]);
      chk("rnd_s_ready", 32'(s_ready), 32'(exp_sr));
      for (int i = 0; i < N; i++)
        if (!rst && chq[i].size() != 0 && m_ready[i])
          chk($sformatf("rnd_pop_data%0d", i), 32'(m_data[i]), 32'(chq[i][0]));
      hold = s_valid && !exp_sr && !rst;
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          chq[i].delete();
          last_d[i] = '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (chq[i].size() != 0 && m_ready[i]) void'(chq[i].pop_front());
          if (s_valid && exp_sr && (int'(s_sel) == i)) begin
            chq[i].push_back(s_data);
            last_d[i] = s_data;
          end
        end
      end
      #1;
      for (int i = 0; i < N; i++) exp_mv[i] = (chq[i].size() != 0);
      chk("rnd_m_valid", 32'(m_valid), 32'(exp_mv));
      for (int i = 0; i < N; i++)
        chk($sformatf("rnd_m_data%0d", i), 32'(m_data[i]), 32'(last_d[i]));
    end

`ifdef STREAM_DEMUX_1_N_COUNT_EN
    rst = 1'b1; s_valid = 1'b0; m_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_after_rst", 32'(m_count), 32'h0);
    rst = 1'b0; s_valid = 1'b1; s_sel = 2'd0; s_data = 4'h3; m_ready = 4'b0001;
    // First accept fills the slot; every following edge pops one word.
    repeat (302) @(posedge clk);
    #1;
    chk("cnt0_saturated", 32'(m_count[0]), 32'd255);
    chk("cnt_others_zero", 32'({m_count[3], m_count[2], m_count[1]}), 32'h0);
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    chk("cnt0_cleared", 32'(m_count[0]), 32'h0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_n.md
Name: stream_demux_1_n

Overview:
- Sequential counterpart of the team's N:1 data-select multiplexers: one input stream, routed to one of N output channels by a per-word select field.
- Each output channel has a one-entry register slot with a valid/ready handshake, so a stalled consumer blocks only words addressed to its own channel.
- Sits between a single producer and N independent consumers in the exercise datapaths.

Parameters:
- WIDTH, 4, data word width in bits (≥1).
- N, 4, number of output channels, power of two, 2..16.
- SEL_W, $clog2(N), select width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_valid  input  1  input word present.
- s_ready  output  1  block accepts the input word this cycle.
- s_data  input  WIDTH  input word.
- s_sel  input  SEL_W  destination channel index.
- m_valid  output  N  per-channel slot-full flag.
- m_ready  input  N  per-channel consumer-ready flag.
- m_data  output  N×WIDTH  packed array [N-1:0][WIDTH-1:0], per-channel slot contents.

Behaviour:
- Reset (rst=1 at edge): all m_valid=0, all m_data=0; s_ready is combinational and reads 0 during reset. Reset mid-transfer discards every slot's contents; no word is delivered after a reset edge unless it is re-sent.
- Input transfer: occurs when s_valid & s_ready at the rising edge.
  - s_ready = ~rst & (~m_valid[s_sel] | m_ready[s_sel]).
  - s_ready depends only on the addressed channel.
- Output transfer on channel i: occurs when m_valid[i] & m_ready[i] at the rising edge.
- Latency: a word accepted at edge k appears on m_data[s_sel] with m_valid[s_sel]=1 after edge k (one cycle). There is no combinational path from s_data to m_data.
- Slot update for channel i, per edge:
  - Accept into i with no pop: load, valid←1.
  - Pop from i with no accept into i: valid←0; data holds its last value.
  - Accept and pop on i in the same cycle: load the new word, valid stays 1, giving full throughput of one word per cycle per channel.
  - Neither: hold.
- Channels are independent: pops on any subset of channels occur in the same cycle as an accept into another channel.
- Ordering: words to the same channel are delivered in acceptance order. No ordering is guaranteed across channels.
- Stability: while m_valid[i]=1 & m_ready[i]=0, m_data[i] is stable. The producer holds s_data and s_sel while s_valid=1 & s_ready=0.
- s_sel or s_data containing X/Z while s_valid=0 has no effect on state.
- Full boundary: all slots full with all m_ready=0 → s_ready=0 for every s_sel, and nothing changes.
- Empty boundary: all m_valid=0 → s_ready=1 for any s_sel.

Optional Feature:
- Macro: STREAM_DEMUX_1_N_COUNT_EN.
- Defined:
  - Adds output port m_count, N×8, packed [N-1:0][7:0].
  - Per-channel count of completed output transfers.
  - Counters saturate at 255, reset to 0 on rst, and increment in the cycle after the pop edge.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package stream_demux_pkg:
  - Defaults DEMUX_WIDTH=4 and DEMUX_N=4.
  - Count width constant DEMUX_CNT_W=8 and saturation value DEMUX_CNT_MAX=8'hFF.
- Sub-module demux_out_slot:
  - One-entry register slot with load/pop/valid/data and the optional counter.
  - Instantiated N times via generate.
- Top level holds only the s_ready select and the per-channel load decode.

Test Plan:
- Reset: rst=1 for 2 cycles with s_valid=1 → m_valid=4'b0000, m_data all 0, s_ready=0; after rst=0, s_ready=1.
- Routing: send s_data='ha,'hb,'hc,'hd with s_sel=0,1,2,3 on consecutive cycles, m_ready=4'b0000 → m_valid=4'b1111 and m_data[0..3]=a,b,c,d; a further word with s_sel=2 sees s_ready=0.
- Backpressure isolation: channel 1 full, m_ready[1]=0; a word 'h7 with s_sel=3 → accepted, and m_data[3]='h7 on the next cycle; m_data[1] unchanged.
- Throughput: m_ready[2]=1 constantly, send 'h1..'h8 back-to-back to s_sel=2 → s_ready stays 1; m_data[2] sequence 1..8, one per cycle, first word one cycle after acceptance.
- Reset mid-operation: slots 0 and 3 full, assert rst for 1 cycle → m_valid=0; previous words never reappear.
- STREAM_DEMUX_1_N_COUNT_EN: 300 pops on channel 0 → m_count[0]=255; m_count[1..3]=0; m_count[0]=0 after rst.
